// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per cycle with a registered carry.
// Latency: start accepted at edge k gives done plus sum/cout/ovf after edge k+NCH.
// Backpressure: start is ignored while busy; there is no output stall.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   ch_add;
    logic             accept, fin, last;

    // Operands shift right each cycle, so the active slice always sits in the low CHUNK bits
    // and the result fills in from the top.
    assign a_ch   = a_q[CHUNK-1:0];
    assign b_ch   = b_q[CHUNK-1:0];
    assign ch_add = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    assign res_d  = WIDTH'({ch_add[CHUNK-1:0], res_q} >> CHUNK);
    assign last   = (cnt_q == LAST);
    assign busy   = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry_q <= sub | cin;
                cnt_q   <= '0;
                res_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                carry_q <= ch_add[CHUNK];
                res_q   <= res_d;
                cnt_q   <= last ? '0 : cnt_q + CW'(1);
            end
            // On the final slice the low bits of a_q/b_q hold the operand MSBs.
            if (fin) begin
                sum  <= res_d;
                cout <= ch_add[CHUNK];
                ovf  <= (a_ch[CHUNK-1] == b_ch[CHUNK-1]) && (ch_add[CHUNK-1] != a_ch[CHUNK-1]);
            end
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder at 16/4, 8/8 and 8/1.
module tb_seq_chunk_adder;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q16[$];
    exp_t q88[$];
    exp_t q81[$];
    int   push_cyc[$];

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0, sub16 = 1'b0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start88 = 1'b0, start81 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        cin8 = 1'b0, sub8 = 1'b0;
    logic        busy88, done88, cout88, ovf88;
    logic        busy81, done81, cout81, ovf81;
    logic [7:0]  sum88, sum81;

    // held-start vectors: operands and hand-computed results
    logic [15:0] ha[3]  = '{16'h8000, 16'h00FF, 16'hA5A5};
    logic [15:0] hb[3]  = '{16'h8000, 16'h0F01, 16'h5A5A};
    logic        hs[3]  = '{1'b0, 1'b0, 1'b1};
    logic [15:0] hr[3]  = '{16'h0000, 16'h1000, 16'h4B4B};
    logic        hc[3]  = '{1'b1, 1'b0, 1'b1};
    logic        ho[3]  = '{1'b1, 1'b0, 1'b1};

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u88 (
        .clk(clk), .rst(rst), .start(start88), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy88), .done(done88), .sum(sum88), .cout(cout88), .ovf(ovf88)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u81 (
        .clk(clk), .rst(rst), .start(start81), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .ovf(ovf81)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [15:0] s,
                       input logic c, input logic o);
        check({tag, " sum"}, 32'(s), 32'(e.sum));
        check({tag, " cout"}, 32'(c), 32'(e.cout));
        check({tag, " ovf"}, 32'(o), 32'(e.ovf));
        check({tag, " done cycle"}, cyc, e.cyc);
    endtask

    task automatic unexpected(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected done: got done=1, expected no completion (cycle %0d)", tag, cyc);
    endtask

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) unexpected("u16");
            else cmp("u16", q16.pop_front(), sum16, cout16, ovf16);
        end
        if (done88 === 1'b1) begin
            if (q88.size() == 0) unexpected("u88");
            else cmp("u88", q88.pop_front(), {8'h00, sum88}, cout88, ovf88);
        end
        if (done81 === 1'b1) begin
            if (q81.size() == 0) unexpected("u81");
            else cmp("u81", q81.pop_front(), {8'h00, sum81}, cout81, ovf81);
        end
    end

    task automatic wait_idle16();
        int n = 0;
        while (busy16 !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy16 !== 1'b0) check("u16 idle timeout", 32'(busy16), 32'd0);
    endtask

    task automatic push16(input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.cyc  = cyc + 5;
        q16.push_back(e);
    endtask

    task automatic issue16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                           input logic is, input logic [15:0] es, input logic ec, input logic eo);
        wait_idle16();
        a16 = ia; b16 = ib; cin16 = ic; sub16 = is; start16 = 1'b1;
        push16(es, ec, eo);
        @(negedge clk);
        start16 = 1'b0;
        check("u16 busy after start", 32'(busy16), 32'd1);
    endtask

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic is, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int n = 0;
        while ((busy88 !== 1'b0 || busy81 !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy81 !== 1'b0) check("u81 idle timeout", 32'(busy81), 32'd0);
        a8 = ia; b8 = ib; cin8 = ic; sub8 = is; start88 = 1'b1; start81 = 1'b1;
        e.sum = {8'h00, es}; e.cout = ec; e.ovf = eo;
        e.cyc = cyc + 2;
        q88.push_back(e);
        e.cyc = cyc + 9;
        q81.push_back(e);
        @(negedge clk);
        start88 = 1'b0; start81 = 1'b0;
        check("u81 busy after start", 32'(busy81), 32'd1);
    endtask

    initial begin
        int idx;
        #1 rst = 1'b1;
        #2;
        check("reset busy", 32'(busy16), 32'd0);
        check("reset done", 32'(done16), 32'd0);
        check("reset sum", 32'(sum16), 32'd0);
        check("reset cout", 32'(cout16), 32'd0);
        check("reset ovf", 32'(ovf16), 32'd0);
        check("reset busy u81", 32'(busy81), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue16(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start held high: operands only matter on idle cycles, junk otherwise
        wait_idle16();
        start16 = 1'b1;
        idx = 0;
        for (int i = 0; i < 60 && idx < 3; i++) begin
            if (busy16 === 1'b0) begin
                a16 = ha[idx]; b16 = hb[idx]; cin16 = 1'b0; sub16 = hs[idx];
                push16(hr[idx], hc[idx], ho[idx]);
                push_cyc.push_back(cyc);
                idx++;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                cin16 = 1'($urandom); sub16 = 1'($urandom);
            end
            @(negedge clk);
        end
        start16 = 1'b0;
        check("u16 held-start accepts", idx, 3);
        if (idx == 3) begin
            check("u16 back-to-back gap 1", push_cyc[1] - push_cyc[0], 5);
            check("u16 back-to-back gap 2", push_cyc[2] - push_cyc[1], 5);
        end

        // reset mid-operation discards it
        wait_idle16();
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun reset busy", 32'(busy16), 32'd0);
        check("midrun reset done", 32'(done16), 32'd0);
        check("midrun reset sum", 32'(sum16), 32'd0);
        check("midrun reset cout", 32'(cout16), 32'd0);
        check("midrun reset ovf", 32'(ovf16), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("u16 idle after reset", 32'(busy16), 32'd0);
        issue16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        issue8(8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0);
        issue8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        issue8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        for (int i = 0; i < 40 && (q16.size() + q88.size() + q81.size()) > 0; i++)
            @(negedge clk);
        check("u16 queue drained", q16.size(), 0);
        check("u88 queue drained", q88.size(), 0);
        check("u81 queue drained", q81.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the team's 1-bit full adder. Each cycle it adds one CHUNK-bit slice of two WIDTH-bit operands and holds the carry in a register between slices, so a wide add costs WIDTH/CHUNK cycles instead of one long combinational carry chain. It sits beside the datapath ALU as an area-cheap wide adder behind a start/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
(Derived) NCH = WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in; sampled with start
sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1), cin ignored; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when a result is written
sum  output  WIDTH  result; held stable between completions
cout  output  1  carry out of MSB; in sub mode 1 = no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow of the result

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal operand/carry/chunk-counter registers=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN.
- IDLE: on an edge with start=1, latch a, b^{WIDTH{sub}} and carry = sub ? 1 : cin. Clear the chunk counter and go to RUN. busy=1 from that edge.
- RUN: each edge processes chunk i (LSB first, bits [i*CHUNK +: CHUNK]). The partial sum goes into the internal result register and the chunk carry-out into the carry register. The counter increments.
- Final chunk (counter = NCH-1): on that edge, write the full result to sum, write the final carry to cout, and set ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B. Set done=1 and busy=0 on the same edge, and return to IDLE.
- Latency: start sampled at edge k means done=1 and a valid sum/cout/ovf after edge k+NCH. Throughput is one operation per NCH+1 cycles.
- done is high for exactly one cycle. start may be high in that same cycle; it is accepted because state is IDLE, so back-to-back operations have a one-cycle gap.
- start while busy=1: ignored, with no effect on the operation in flight. Operand inputs are don't-care while busy.
- sum, cout and ovf change only on a completion edge or reset. Intermediate chunk results are never visible.
- NCH=1 (CHUNK=WIDTH): RUN lasts one edge and done follows start by one cycle.
- Counter width is clog2(NCH), minimum 1 bit. The counter never wraps past NCH-1.

Test Plan:
(WIDTH=16, CHUNK=4 unless noted)
- a=0x1234, b=0x4321, cin=0, sub=0, start pulse at edge k -> busy high for edges k..k+3; done=1 after edge k+4; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. Repeat with cin=1 -> sum=0x0001, cout=1.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- start held high continuously with changing operands -> operands are captured only at IDLE edges. The second result reflects operands present on the done cycle. Mid-run operand changes do not affect the result.
- Assert rst for one cycle two edges after start -> busy=0, done=0, sum=0, cout=0, ovf=0 immediately (asynchronously). No done pulse follows. A fresh start afterwards completes normally in 4 cycles.
- Instantiate WIDTH=8, CHUNK=8 and WIDTH=8, CHUNK=1. Apply a=0xC8, b=0x64 to each -> sum=0x2C, cout=1, ovf=0. done arrives 1 and 8 cycles after start respectively.
